// File: rtl/rtype_control_sequencer_pkg.sv
// Shared definitions for the R-type control sequencer.
// Contents: FSM state encodings, error codes, IR field positions, default opcode masks
// and a helper that sizes register-index fields.
package rtype_control_sequencer_pkg;

    // FSM state encodings
    localparam logic [3:0] StIdle = 4'd0;
    localparam logic [3:0] StT0   = 4'd1;
    localparam logic [3:0] StT1   = 4'd2;
    localparam logic [3:0] StT2   = 4'd3;
    localparam logic [3:0] StT3   = 4'd4;
    localparam logic [3:0] StT4   = 4'd5;
    localparam logic [3:0] StT5   = 4'd6;
    localparam logic [3:0] StT6   = 4'd7;
    localparam logic [3:0] StDone = 4'd8;

    // Completion status reported at DONE
    typedef enum logic [1:0] {
        ErrNone       = 2'd0,
        ErrIllegal    = 2'd1,
        ErrMemTimeout = 2'd2
    } err_e;

    // Opcode occupies the top bits of IR; register fields follow directly below it
    localparam int unsigned IrMsb = 31;

    localparam logic [31:0] DefLegalOpMask = 32'h0001_FFFF;
    localparam logic [31:0] DefWideOpMask  = 32'h0001_8000;

    // Bits needed to index n items (at least one bit)
    function automatic int unsigned field_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtype_control_sequencer_if.sv
// Handshake and strobe bundle between the sequencer and its surroundings.
// master: the sequencer (takes start/mem_ready/ir_word, drives every strobe and status).
// slave : top-level control plus datapath (the opposite directions).
// Signals: start, mem_ready, ir_word[31:0]; reg_in/reg_out[NUM_REGS]; PC, memory, IR, Y, Z,
// LO/HI strobes; op_code[OP_W]; busy, done, error (err_e).
interface rtype_control_sequencer_if
    import rtype_control_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned OP_W     = 5
);
    logic                start;
    logic                mem_ready;
    logic [31:0]         ir_word;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic                pc_out;
    logic                pc_in;
    logic                pc_increment;
    logic                mar_in;
    logic                mdr_in;
    logic                mdr_out;
    logic                read;
    logic                ir_in;
    logic                y_in;
    logic                zlow_in;
    logic                zhigh_in;
    logic                zlow_out;
    logic                zhigh_out;
    logic                lo_in;
    logic                hi_in;
    logic [OP_W-1:0]     op_code;
    logic                busy;
    logic                done;
    err_e                error;

    modport master (
        input  start, mem_ready, ir_word,
        output reg_in, reg_out, pc_out, pc_in, pc_increment, mar_in, mdr_in, mdr_out, read,
               ir_in, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in, op_code,
               busy, done, error
    );

    modport slave (
        output start, mem_ready, ir_word,
        input  reg_in, reg_out, pc_out, pc_in, pc_increment, mar_in, mdr_in, mdr_out, read,
               ir_in, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in, op_code,
               busy, done, error
    );

endinterface

// File: rtl/rtype_ir_decode.sv
// Combinational IR field decode.
// Ports: ir_word (in, 32) -> opcode (OP_W), ra_oh/rb_oh/rc_oh (NUM_REGS one-hot),
//        legal (opcode allowed and all register fields in range), wide (HI/LO result op).
module rtype_ir_decode
    import rtype_control_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 16,
    parameter int unsigned OP_W          = 5,
    parameter logic [31:0] LEGAL_OP_MASK = DefLegalOpMask,
    parameter logic [31:0] WIDE_OP_MASK  = DefWideOpMask
) (
    input  logic [31:0]         ir_word,
    output logic [OP_W-1:0]     opcode,
    output logic [NUM_REGS-1:0] ra_oh,
    output logic [NUM_REGS-1:0] rb_oh,
    output logic [NUM_REGS-1:0] rc_oh,
    output logic                legal,
    output logic                wide
);
    localparam int unsigned RegW = field_width(NUM_REGS);
    localparam int unsigned RaMsb = IrMsb - OP_W;
    localparam int unsigned RbMsb = RaMsb - RegW;
    localparam int unsigned RcMsb = RbMsb - RegW;
    localparam int unsigned LowW  = RcMsb + 1 - RegW;

    logic [RegW-1:0] ra, rb, rc;
    logic            op_ok, regs_ok;

    assign opcode = ir_word[IrMsb -: OP_W];
    assign ra     = ir_word[RaMsb -: RegW];
    assign rb     = ir_word[RbMsb -: RegW];
    assign rc     = ir_word[RcMsb -: RegW];

    // Out-of-range indices shift the one past the top and decode to no register
    assign ra_oh = NUM_REGS'(1) << ra;
    assign rb_oh = NUM_REGS'(1) << rb;
    assign rc_oh = NUM_REGS'(1) << rc;

    // Shift form keeps opcodes beyond bit 31 of the mask illegal instead of out of range
    assign op_ok   = ((LEGAL_OP_MASK >> opcode) & 32'd1) != 32'd0;
    assign wide    = ((WIDE_OP_MASK >> opcode) & 32'd1) != 32'd0;
    assign regs_ok = (32'(ra) < NUM_REGS) && (32'(rb) < NUM_REGS) && (32'(rc) < NUM_REGS);
    assign legal   = op_ok && regs_ok;

    generate
        if (LowW > 0) begin : g_low
            logic unused_ir_low;
            assign unused_ir_low = ^ir_word[LowW-1:0];
        end
    endgenerate

endmodule

// File: rtl/rtype_control_sequencer.sv
// Control-step generator: fetch (T0-T2) then R-type execute (T3-T5, T6 for HI/LO ops).
// Ports: clk, clr (async active-high reset), bus (master modport: start, mem_ready, ir_word in;
// register/PC/memory/IR/Y/Z/LO/HI strobes, op_code, busy, done, error out).
// Outputs are a decode of the state register; ir_word is the IR register output, so the
// register-select path is register-to-register through the field decode.
module rtype_control_sequencer
    import rtype_control_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 16,
    parameter int unsigned OP_W          = 5,
    parameter logic [31:0] LEGAL_OP_MASK = DefLegalOpMask,
    parameter logic [31:0] WIDE_OP_MASK  = DefWideOpMask,
    parameter int unsigned MEM_TIMEOUT   = 15
) (
    input logic                        clk,
    input logic                        clr,
    rtype_control_sequencer_if.master  bus
);
    localparam int unsigned CntW = field_width(MEM_TIMEOUT);
    localparam logic [CntW-1:0] WaitLast = CntW'(MEM_TIMEOUT - 1);

    logic [3:0]          state_q, state_d;
    logic [CntW-1:0]     wait_q, wait_d;
    err_e                error_q, error_d;

    logic [OP_W-1:0]     opcode;
    logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
    logic                legal, wide;

    rtype_ir_decode #(
        .NUM_REGS      (NUM_REGS),
        .OP_W          (OP_W),
        .LEGAL_OP_MASK (LEGAL_OP_MASK),
        .WIDE_OP_MASK  (WIDE_OP_MASK)
    ) u_ir_decode (
        .ir_word (bus.ir_word),
        .opcode  (opcode),
        .ra_oh   (ra_oh),
        .rb_oh   (rb_oh),
        .rc_oh   (rc_oh),
        .legal   (legal),
        .wide    (wide)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        error_d = error_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StT0;
                    error_d = ErrNone;
                end
            end
            StT0: state_d = StT1;
            StT1: begin
                if (bus.mem_ready) begin
                    state_d = StT2;
                end else if (wait_q == WaitLast) begin
                    state_d = StDone;
                    error_d = ErrMemTimeout;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            StT2: state_d = StT3;
            StT3: begin
                if (legal) begin
                    state_d = StT4;
                end else begin
                    state_d = StDone;
                    error_d = ErrIllegal;
                end
            end
            StT4:    state_d = StT5;
            StT5:    state_d = wide ? StT6 : StDone;
            StT6:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            wait_q  <= '0;
            error_q <= ErrNone;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        bus.reg_in       = '0;
        bus.reg_out      = '0;
        bus.pc_out       = 1'b0;
        bus.pc_in        = 1'b0;
        bus.pc_increment = 1'b0;
        bus.mar_in       = 1'b0;
        bus.mdr_in       = 1'b0;
        bus.mdr_out      = 1'b0;
        bus.read         = 1'b0;
        bus.ir_in        = 1'b0;
        bus.y_in         = 1'b0;
        bus.zlow_in      = 1'b0;
        bus.zhigh_in     = 1'b0;
        bus.zlow_out     = 1'b0;
        bus.zhigh_out    = 1'b0;
        bus.lo_in        = 1'b0;
        bus.hi_in        = 1'b0;
        bus.op_code      = '0;
        bus.done         = 1'b0;
        case (state_q)
            StT0: begin
                bus.pc_out       = 1'b1;
                bus.pc_increment = 1'b1;
                bus.mar_in       = 1'b1;
                bus.zlow_in      = 1'b1;
                bus.zhigh_in     = 1'b1;
            end
            StT1: begin
                bus.zlow_out = 1'b1;
                // Load PC+1 only once; a stall must not reload it
                bus.pc_in    = (wait_q == '0);
                bus.read     = 1'b1;
                bus.mdr_in   = 1'b1;
            end
            StT2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
            end
            StT3: begin
                bus.reg_out = rb_oh;
                bus.y_in    = 1'b1;
            end
            StT4: begin
                bus.reg_out  = rc_oh;
                bus.zlow_in  = 1'b1;
                bus.zhigh_in = 1'b1;
                bus.op_code  = opcode;
            end
            StT5: begin
                bus.zlow_out = 1'b1;
                if (wide) begin
                    bus.lo_in = 1'b1;
                end else begin
                    bus.reg_in = ra_oh;
                end
            end
            StT6: begin
                bus.zhigh_out = 1'b1;
                bus.hi_in     = 1'b1;
            end
            StDone:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.error = error_q;

endmodule

// File: tb/tb_rtype_control_sequencer.sv
// Directed bench for rtype_control_sequencer. Inputs change and outputs are sampled on the
// falling clock edge; each cycle's full output image is compared against a hand-built vector.
module tb_rtype_control_sequencer;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    rtype_control_sequencer_if #(.NUM_REGS(16), .OP_W(5)) bus ();

    rtype_control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Strobe image bit masks
    localparam logic [16:0] M_PC_OUT   = 17'd1 << 16;
    localparam logic [16:0] M_PC_IN    = 17'd1 << 15;
    localparam logic [16:0] M_PC_INC   = 17'd1 << 14;
    localparam logic [16:0] M_MAR_IN   = 17'd1 << 13;
    localparam logic [16:0] M_MDR_IN   = 17'd1 << 12;
    localparam logic [16:0] M_MDR_OUT  = 17'd1 << 11;
    localparam logic [16:0] M_READ     = 17'd1 << 10;
    localparam logic [16:0] M_IR_IN    = 17'd1 << 9;
    localparam logic [16:0] M_Y_IN     = 17'd1 << 8;
    localparam logic [16:0] M_ZLOW_IN  = 17'd1 << 7;
    localparam logic [16:0] M_ZHIGH_IN = 17'd1 << 6;
    localparam logic [16:0] M_ZLOW_OUT = 17'd1 << 5;
    localparam logic [16:0] M_ZHI_OUT  = 17'd1 << 4;
    localparam logic [16:0] M_LO_IN    = 17'd1 << 3;
    localparam logic [16:0] M_HI_IN    = 17'd1 << 2;
    localparam logic [16:0] M_BUSY     = 17'd1 << 1;
    localparam logic [16:0] M_DONE     = 17'd1 << 0;

    localparam logic [16:0] E_T0  = M_PC_OUT | M_PC_INC | M_MAR_IN | M_ZLOW_IN | M_ZHIGH_IN
                                    | M_BUSY;
    localparam logic [16:0] E_T1F = M_ZLOW_OUT | M_PC_IN | M_READ | M_MDR_IN | M_BUSY;
    localparam logic [16:0] E_T1  = M_ZLOW_OUT | M_READ | M_MDR_IN | M_BUSY;
    localparam logic [16:0] E_T2  = M_MDR_OUT | M_IR_IN | M_BUSY;
    localparam logic [16:0] E_T3  = M_Y_IN | M_BUSY;
    localparam logic [16:0] E_T4  = M_ZLOW_IN | M_ZHIGH_IN | M_BUSY;
    localparam logic [16:0] E_T5N = M_ZLOW_OUT | M_BUSY;
    localparam logic [16:0] E_T5W = M_ZLOW_OUT | M_LO_IN | M_BUSY;
    localparam logic [16:0] E_T6  = M_ZHI_OUT | M_HI_IN | M_BUSY;
    localparam logic [16:0] E_DN  = M_BUSY | M_DONE;

    localparam logic [31:0] IR_ROL = 32'h421B_8000;  // op 8, Ra 4, Rb 3, Rc 7
    localparam logic [31:0] IR_MUL = 32'h781B_8000;  // op 15, Ra 0, Rb 3, Rc 7
    localparam logic [31:0] IR_BAD = 32'hF81B_8000;  // op 31, Rb 3

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_start = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] snap();
        return {10'b0, bus.pc_out, bus.pc_in, bus.pc_increment, bus.mar_in, bus.mdr_in,
                bus.mdr_out, bus.read, bus.ir_in, bus.y_in, bus.zlow_in, bus.zhigh_in,
                bus.zlow_out, bus.zhigh_out, bus.lo_in, bus.hi_in, bus.busy, bus.done,
                bus.reg_in, bus.reg_out, bus.op_code};
    endfunction

    function automatic logic [63:0] ev(input logic [16:0] s, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [4:0] op);
        return {10'b0, s, rin, rout, op};
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Pulse start for one edge; returns in T0 with the error latch already cleared
    task automatic launch(input string tag, input logic [31:0] ir);
        bus.ir_word = ir;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        t_start = cyc;
        check({tag, ".t0"}, snap(), ev(E_T0, 16'd0, 16'd0, 5'd0));
        check({tag, ".err_clr"}, 64'(bus.error), 64'd0);
    endtask

    task automatic run_nostall(input string tag, input logic [31:0] ir, input int rb,
                               input int rc, input int ra, input logic [4:0] op,
                               input bit wide, input int exp_lat);
        launch(tag, ir);
        step(); check({tag, ".t1"}, snap(), ev(E_T1F, 16'd0, 16'd0, 5'd0));
        step(); check({tag, ".t2"}, snap(), ev(E_T2, 16'd0, 16'd0, 5'd0));
        step(); check({tag, ".t3"}, snap(), ev(E_T3, 16'd0, 16'd1 << rb, 5'd0));
        step(); check({tag, ".t4"}, snap(), ev(E_T4, 16'd0, 16'd1 << rc, op));
        step();
        if (wide) begin
            check({tag, ".t5"}, snap(), ev(E_T5W, 16'd0, 16'd0, 5'd0));
            step(); check({tag, ".t6"}, snap(), ev(E_T6, 16'd0, 16'd0, 5'd0));
        end else begin
            check({tag, ".t5"}, snap(), ev(E_T5N, 16'd1 << ra, 16'd0, 5'd0));
        end
        step(); check({tag, ".done"}, snap(), ev(E_DN, 16'd0, 16'd0, 5'd0));
        check({tag, ".lat"}, 64'(cyc - t_start), 64'(exp_lat));
        check({tag, ".err"}, 64'(bus.error), 64'd0);
        step(); check({tag, ".idle"}, snap(), 64'd0);
    endtask

    initial begin
        int irc, t1c, pcc;
        bus.start = 1'b0;
        bus.mem_ready = 1'b1;
        bus.ir_word = 32'd0;

        #2;
        check("reset.outs", snap(), 64'd0);
        check("reset.err", 64'(bus.error), 64'd0);
        step();
        clr = 1'b0;
        step();
        check("idle.outs", snap(), 64'd0);

        // 1. ROL, narrow writeback
        run_nostall("rol", IR_ROL, 3, 7, 4, 5'd8, 1'b0, 6);

        // 2. MUL, wide writeback through LO/HI
        run_nostall("mul", IR_MUL, 3, 7, 0, 5'd15, 1'b1, 7);

        // 5. Illegal opcode: aborts after T3 with no execute strobes
        launch("ill", IR_BAD);
        step(); check("ill.t1", snap(), ev(E_T1F, 16'd0, 16'd0, 5'd0));
        step(); check("ill.t2", snap(), ev(E_T2, 16'd0, 16'd0, 5'd0));
        step(); check("ill.t3", snap(), ev(E_T3, 16'd0, 16'd1 << 3, 5'd0));
        step(); check("ill.done", snap(), ev(E_DN, 16'd0, 16'd0, 5'd0));
        check("ill.lat", 64'(cyc - t_start), 64'd4);
        check("ill.err", 64'(bus.error), 64'd1);
        step(); check("ill.idle", snap(), 64'd0);

        // 3. Three-cycle memory stall; pc_in only in the first T1 cycle
        bus.mem_ready = 1'b0;
        launch("stall", IR_ROL);
        step(); check("stall.t1a", snap(), ev(E_T1F, 16'd0, 16'd0, 5'd0));
        step(); check("stall.t1b", snap(), ev(E_T1, 16'd0, 16'd0, 5'd0));
        step(); check("stall.t1c", snap(), ev(E_T1, 16'd0, 16'd0, 5'd0));
        step(); check("stall.t1d", snap(), ev(E_T1, 16'd0, 16'd0, 5'd0));
        bus.mem_ready = 1'b1;
        step(); check("stall.t2", snap(), ev(E_T2, 16'd0, 16'd0, 5'd0));
        step(); check("stall.t3", snap(), ev(E_T3, 16'd0, 16'd1 << 3, 5'd0));
        step(); check("stall.t4", snap(), ev(E_T4, 16'd0, 16'd1 << 7, 5'd8));
        step(); check("stall.t5", snap(), ev(E_T5N, 16'd1 << 4, 16'd0, 5'd0));
        step(); check("stall.done", snap(), ev(E_DN, 16'd0, 16'd0, 5'd0));
        check("stall.lat", 64'(cyc - t_start), 64'd9);
        step();

        // 4. Memory never ready: timeout after 15 T1 cycles
        bus.mem_ready = 1'b0;
        launch("tmo", IR_ROL);
        irc = 0; t1c = 0; pcc = 0;
        for (int i = 0; i < 40 && !bus.done; i++) begin
            if (bus.ir_in) irc++;
            if (bus.read) t1c++;
            if (bus.pc_in) pcc++;
            step();
        end
        check("tmo.done", 64'(bus.done), 64'd1);
        check("tmo.lat", 64'(cyc - t_start), 64'd16);
        check("tmo.t1_cycles", 64'(t1c), 64'd15);
        check("tmo.ir_in", 64'(irc), 64'd0);
        check("tmo.pc_in", 64'(pcc), 64'd1);
        check("tmo.err", 64'(bus.error), 64'd2);
        bus.mem_ready = 1'b1;
        step(); check("tmo.idle", snap(), 64'd0);

        // 6. start while busy is ignored; clr mid-T4 aborts at once
        launch("abort", IR_ROL);
        step();
        step();
        bus.start = 1'b1;
        step(); check("abort.start_ign", snap(), ev(E_T3, 16'd0, 16'd1 << 3, 5'd0));
        bus.start = 1'b0;
        step(); check("abort.t4", snap(), ev(E_T4, 16'd0, 16'd1 << 7, 5'd8));
        #1 clr = 1'b1;
        #1 check("abort.outs", snap(), 64'd0);
        step();
        clr = 1'b0;
        step(); check("abort.idle1", snap(), 64'd0);
        step(); check("abort.idle2", snap(), 64'd0);
        run_nostall("rerun", IR_ROL, 3, 7, 4, 5'd8, 1'b0, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
